// File: rtl/cmd_arbiter.sv
// Round-robin command arbiter: several masters share one downstream command
// port. One transaction is outstanding at a time, bounded by a timeout that
// completes the request with a recognisable error word.
module cmd_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_BITS      = 16,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             i_sys_clk,
  input  logic                             i_sys_rst,
  input  logic [NUM_MASTERS-1:0]           i_req_sel,
  input  logic [NUM_MASTERS-1:0]           i_req_rd_wr_n,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] i_req_byte_addr,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] i_req_wdata,
  output logic [NUM_MASTERS-1:0]           o_req_ack,
  output logic [DATA_BITS-1:0]             o_req_rdata,
  output logic                             o_mem_sel,
  output logic                             o_mem_rd_wr_n,
  output logic [ADDR_BITS-1:0]             o_mem_byte_addr,
  output logic [DATA_BITS-1:0]             o_mem_wdata,
  input  logic                             i_mem_ack,
  input  logic [DATA_BITS-1:0]             i_mem_rdata,
  output logic [NUM_MASTERS-1:0]           o_grant,
  output logic                             o_timeout
);

  localparam int GW = $clog2(NUM_MASTERS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Error word returned on timeout, sized to the data bus.
  localparam logic [DATA_BITS-1:0] TIMEOUT_DATA = DATA_BITS'(32'hDEADBEEF);
  // Counter value seen in the last WAIT cycle before the timeout fires.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [GW-1:0]        last_grant;
  logic [15:0]          wait_count;

  logic                 found;
  logic [GW-1:0]        next_owner;
  logic                 sel_rd_wr_n;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  int                   cand;

  // Pick the first requester above the last served master and mux its command.
  always_comb begin
    found       = 1'b0;
    next_owner  = last_grant;
    sel_rd_wr_n = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    cand        = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = (int'(last_grant) + off) % NUM_MASTERS;
      if (!found && i_req_sel[cand]) begin
        found       = 1'b1;
        next_owner  = GW'(cand);
        sel_rd_wr_n = i_req_rd_wr_n[cand];
        sel_addr    = i_req_byte_addr[cand*ADDR_BITS +: ADDR_BITS];
        sel_wdata   = i_req_wdata[cand*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Transaction sequencing: grant, wait for ack or timeout, one retire cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state           <= ST_IDLE;
      last_grant      <= GW'(NUM_MASTERS - 1);
      wait_count      <= '0;
      o_mem_sel       <= 1'b0;
      o_mem_rd_wr_n   <= 1'b0;
      o_mem_byte_addr <= '0;
      o_mem_wdata     <= '0;
      o_req_ack       <= '0;
      o_req_rdata     <= '0;
      o_grant         <= '0;
      o_timeout       <= 1'b0;
    end else begin
      o_req_ack   <= '0;
      o_req_rdata <= '0;
      o_timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            last_grant      <= next_owner;
            o_grant         <= NUM_MASTERS'(1) << next_owner;
            o_mem_sel       <= 1'b1;
            o_mem_rd_wr_n   <= sel_rd_wr_n;
            o_mem_byte_addr <= sel_addr;
            o_mem_wdata     <= sel_wdata;
            wait_count      <= '0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_count <= wait_count + 16'd1;
          if (i_mem_ack) begin
            o_mem_sel   <= 1'b0;
            o_req_ack   <= NUM_MASTERS'(1) << last_grant;
            o_req_rdata <= i_mem_rdata;
            state       <= ST_DONE;
          end else if (wait_count == WAIT_LAST) begin
            o_mem_sel   <= 1'b0;
            o_req_ack   <= NUM_MASTERS'(1) << last_grant;
            o_req_rdata <= TIMEOUT_DATA;
            o_timeout   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_grant <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting command ports (2..16).
REQ-002 SHALL have parameter ADDR_BITS, default 16, byte address width.
REQ-003 SHALL have parameter DATA_BITS, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for the downstream ack (1..65535).
REQ-005 SHALL have port i_sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_sys_rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_req_sel  in  NUM_MASTERS  per-master request, held high until its ack.
REQ-008 SHALL have port i_req_rd_wr_n  in  NUM_MASTERS  per-master direction (1 = read).
REQ-009 SHALL have port i_req_byte_addr  in  NUM_MASTERS*ADDR_BITS  packed addresses, master m at bits [m*ADDR_BITS +: ADDR_BITS].
REQ-010 SHALL have port i_req_wdata  in  NUM_MASTERS*DATA_BITS  packed write data, same packing.
REQ-011 SHALL have port o_req_ack  out  NUM_MASTERS  one-cycle completion pulse per master.
REQ-012 SHALL have port o_req_rdata  out  DATA_BITS  read data, valid when any o_req_ack bit is high.
REQ-013 SHALL have ports o_mem_sel, o_mem_rd_wr_n (out, 1), o_mem_byte_addr (out, ADDR_BITS), o_mem_wdata (out, DATA_BITS)  downstream command.
REQ-014 SHALL have ports i_mem_ack (in, 1) and i_mem_rdata (in, DATA_BITS)  downstream completion.
REQ-015 SHALL have port o_grant  out  NUM_MASTERS  one-hot current owner; zero when idle.
REQ-016 SHALL have port o_timeout  out  1  one-cycle pulse on a timed-out transaction.

Function
REQ-017 SHALL implement states IDLE, WAIT, DONE.
REQ-018 In IDLE with any i_req_sel bit high, SHALL grant round-robin: the first set bit searching upward from (last_grant+1) mod NUM_MASTERS, wrapping.
REQ-019 On grant, SHALL register the owner's rd_wr_n, byte_addr and wdata, set o_grant, and assert o_mem_sel on the next cycle (request sampled at cycle 0 -> o_mem_sel high at cycle 1), then enter WAIT.
REQ-020 The o_mem_* outputs SHALL hold stable throughout WAIT and SHALL NOT follow changes on the requester inputs.
REQ-021 In WAIT, i_mem_ack high at cycle k SHALL produce: o_mem_sel low, o_req_ack[owner] high for exactly one cycle and o_req_rdata = i_mem_rdata (registered), all at cycle k+1; the FSM then enters DONE.
REQ-022 DONE SHALL last one cycle; o_grant clears on leaving DONE; the FSM returns to IDLE. A new request can therefore be granted no earlier than 2 cycles after the ack pulse.
REQ-023 A WAIT counter SHALL clear on entry and increment every cycle; on reaching TIMEOUT_CYCLES without i_mem_ack, the block SHALL drop o_mem_sel, pulse o_req_ack[owner] with o_req_rdata = 0xDEADBEEF (truncated/zero-extended to DATA_BITS), pulse o_timeout, and enter DONE.
REQ-024 If i_mem_ack and the timeout occur in the same cycle, the ack SHALL win and o_timeout SHALL stay low.
REQ-025 i_mem_ack outside WAIT SHALL be ignored.
REQ-026 An owner dropping i_req_sel during WAIT SHALL NOT abort the transaction; the ack is still pulsed.
REQ-027 last_grant SHALL update only on grant, so the priority rotates past the most recently served master.
REQ-028 o_req_ack SHALL never have more than one bit set; o_req_rdata SHALL be 0 whenever o_req_ack is 0.

Reset
REQ-029 While i_sys_rst is high, SHALL force IDLE with o_mem_sel, o_mem_rd_wr_n, o_mem_byte_addr, o_mem_wdata, o_req_ack, o_req_rdata, o_grant and o_timeout all 0, and the WAIT counter at 0.
REQ-030 Reset SHALL set last_grant = NUM_MASTERS-1 so that master 0 has the highest priority first.
REQ-031 Reset during WAIT SHALL abandon the transaction without an ack; a downstream ack arriving after reset SHALL be ignored.

Verification
REQ-032 Single read: master 2 requests addr 0x0040; i_mem_ack at cycle 4 with rdata 0x12345678 -> o_mem_sel high cycles 1-4, o_req_ack[2] and rdata 0x12345678 at cycle 5, o_grant = 0b0100 through cycle 5.
REQ-033 Round-robin: all 4 masters request continuously with ack 1 cycle after sel -> grant order 0,1,2,3,0, with no master served twice before the others.
REQ-034 Timeout: TIMEOUT_CYCLES = 8, master 1 write, no ack -> o_timeout and o_req_ack[1] pulse at cycle 9, rdata 0xDEADBEEF, o_mem_sel low at cycle 9.
REQ-035 Collision: i_mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES with rdata 0xA5A5A5A5 -> normal ack with 0xA5A5A5A5, o_timeout stays low.
REQ-036 Reset mid-WAIT (master 3), then i_mem_ack 2 cycles after reset release -> no o_req_ack pulse, all outputs 0, next simultaneous request from masters 0 and 3 grants master 0.
REQ-037 Requester glitch: master 0 drops sel during WAIT, wdata changes 0x1 -> 0x2 -> o_mem_wdata stays 0x1 and o_req_ack[0] still pulses on ack.
